// File: rtl/mult_seq_ctrl.sv
// Sequential 32x32 sign-magnitude shift-add multiplier controller that drives a shared adder.
// Define MULT_SIGNED_EN to honor is_signed; otherwise both operands are treated as unsigned.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  typedef enum logic [2:0] {
    IDLE, PREP_A, PREP_B, MUL, FIX_LO, FIX_HI, DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] mcand;
  logic [4:0]       cnt;
  logic             neg_a;
  logic             neg_b;
  logic             neg_p;
  logic             carry;
  logic             sgn;

`ifdef MULT_SIGNED_EN
  assign sgn = is_signed;
`else
  logic unused_sign;
  assign sgn = 1'b0;
  assign unused_sign = is_signed;
`endif

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state)
      PREP_A: begin
        add_a   = neg_a ? ~a_q : a_q;
        add_cin = neg_a;
      end
      PREP_B: begin
        add_a   = neg_b ? ~b_q : b_q;
        add_cin = neg_b;
      end
      MUL: begin
        add_a = hi;
        add_b = lo[0] ? mcand : '0;
      end
      FIX_LO: begin
        add_a   = neg_p ? ~lo : lo;
        add_cin = neg_p;
      end
      // low-word carry only ripples into hi when negating
      FIX_HI: begin
        add_a   = neg_p ? ~hi : hi;
        add_cin = neg_p & carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      neg_p <= 1'b0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            neg_a <= sgn & a[WIDTH-1];
            neg_b <= sgn & b[WIDTH-1];
            neg_p <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            busy  <= 1'b1;
            state <= PREP_A;
          end else begin
            state <= IDLE;
          end
        end
        PREP_A: begin
          mcand <= add_sum;
          state <= PREP_B;
        end
        PREP_B: begin
          lo    <= add_sum;
          hi    <= '0;
          cnt   <= '0;
          state <= MUL;
        end
        MUL: begin
          hi  <= {add_cout, add_sum[WIDTH-1:1]};
          lo  <= {add_sum[0], lo[WIDTH-1:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= FIX_LO;
        end
        FIX_LO: begin
          lo    <= add_sum;
          carry <= add_cout;
          state <= FIX_HI;
        end
        FIX_HI: begin
          hi    <= add_sum;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: ideal adder beside the DUT, 64-bit product reference.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;

  int          checks = 0;
  int          passed = 0;
  int          fails = 0;
  logic [63:0] last = '0;

`ifdef MULT_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  mult_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  assign {add_cout, add_sum} =
    {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  function automatic logic [63:0] ref_prod(
    input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe;
    logic [63:0] ye;
    logic        e;
    e  = s & SEN;
    xe = e ? {{32{x[31]}}, x} : {32'b0, x};
    ye = e ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] req);
    checks++;
    assert (obs === req) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic s, input bit poke);
    logic [63:0] want;
    int          edges;
    int          bcyc;
    want = ref_prod(x, y, s);
    a = x;
    b = y;
    is_signed = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_at_prep_a", {63'b0, busy}, 64'd1);
    chk("hold_at_prep_a", {hi, lo}, last);
    edges = 1;
    bcyc = 0;
    while (!done && edges < 100) begin
      if (busy) bcyc++;
      if (poke && edges == 10) begin
        start = 1'b1;
        a = $urandom;
        b = $urandom;
        is_signed = ~s;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    chk("latency", 64'(edges), 64'd37);
    chk("busy_cycles", 64'(bcyc), 64'd36);
    chk("product", {hi, lo}, want);
    last = want;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_pulse", {63'b0, done}, 64'd0);
    chk("idle_busy", {63'b0, busy}, 64'd0);
    chk("idle_adder", {31'b0, add_cin, add_a}, 64'd0);
    chk("idle_add_b", {32'b0, add_b}, 64'd0);
    chk("idle_hold", {hi, lo}, last);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_adder", {31'b0, add_cin, add_a}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    idle_check();

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    idle_check();

    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    chk("min_sq", {hi, lo}, 64'h4000_0000_0000_0000);
    idle_check();

    run_op(32'h0, 32'hFFFF_FFFB, 1'b1, 1'b0);
    chk("zero_neg", {hi, lo}, 64'd0);
    run_op(32'd7, 32'd6, 1'b0, 1'b0);
    chk("b2b_7x6", {hi, lo}, 64'd42);
    idle_check();

    run_op($urandom, $urandom, 1'b1, 1'b1);
    idle_check();

    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    is_signed = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("mid_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    last = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    idle_check();

    for (int i = 0; i < 16; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle_check();
    end
    idle_check();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
